hood_mode_scheduler: RTL and testbench
======================================

# hood_mode_scheduler

Central mode scheduler for the exhaust hood. It owns the `current_mode` register that the per-mode toggle controllers read, and it consumes their one-cycle toggle pulses. It enforces the mode rules:
- hurricane (third mode) is allowed once per reset;
- hurricane auto-falls to second mode after a timed run;
- leaving hurricane for standby passes through a timed fan cooldown.

It sits between the first/second/third mode controllers and the fan, display and countdown logic.

## Interface
- `THIRD_SECONDS`, default 60: hurricane run length, in `tick` pulses.
- `COOLDOWN_SECONDS`, default 60: post-hurricane cooldown length, in `tick` pulses.
- `CNT_WIDTH`, default 8: width of `remaining`; must hold max(THIRD_SECONDS, COOLDOWN_SECONDS).

Clocking and reset (already decided): one clock; reset is asynchronous and active-high.

Ports:
- `clk` input 1: system clock; all state changes on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `tick` input 1: 1 Hz enable pulse, one `clk` cycle wide.
- `first_mode_toggle` input 1: pulse from the first mode controller.
- `second_mode_toggle` input 1: pulse from the second mode controller.
- `third_mode_toggle` input 1: pulse from the third mode controller.
- `stand_request` input 1: pulse; the user asks to return to standby.
- `current_mode` output `` `MODE_WIDTH ``: mode encoding from parameters.vh (`` `STAND_MODE ``/`` `FIRST_MODE ``/`` `SECOND_MODE ``/`` `THIRD_MODE ``).
- `remaining` output CNT_WIDTH: seconds left in a timed state; 0 otherwise.
- `cooldown_active` output 1: high while in COOLDOWN.
- `hurricane_used` output 1: sticky; set on the first entry to THIRD.
- `third_denied` output 1: one-cycle registered pulse when a third-mode request is refused.

## Operation
- Internal states are STAND, FIRST, SECOND, THIRD and COOLDOWN.
- `current_mode` mapping:
  - COOLDOWN reports `` `SECOND_MODE ``, because the fan keeps running.
  - Every other state reports its own encoding.
- Reset values: state STAND, `current_mode` = `` `STAND_MODE ``, `remaining` = 0, `cooldown_active` = 0, `hurricane_used` = 0, `third_denied` = 0.
- Reset is the only way to clear `hurricane_used`.
- Within one cycle, request priority is `stand_request` > third > second > first. Only the highest-priority request that is legal in the current state acts; all others that cycle are dropped, not queued.
- A third request is "legal" only when `hurricane_used` = 0. An illegal third request pulses `third_denied` and does not block lower-priority requests in the same cycle.

State transitions:
- STAND:
  - legal third → THIRD;
  - second → SECOND;
  - first → FIRST;
  - `stand_request` → no effect.
- FIRST:
  - `stand_request` → STAND;
  - legal third → THIRD;
  - second → SECOND;
  - first (toggle off) → STAND.
- SECOND:
  - `stand_request` → STAND;
  - legal third → THIRD;
  - first → FIRST;
  - second (toggle off) → STAND.
- THIRD:
  - `stand_request` or `third_mode_toggle` → COOLDOWN;
  - first and second toggles are ignored;
  - timer expiry → SECOND.
  - An explicit request in the expiry cycle wins over the expiry.
- COOLDOWN:
  - all requests are ignored, and no `third_denied` pulse is generated;
  - timer expiry → STAND.
- Entry into THIRD sets `hurricane_used` = 1 on the same edge.

Timer rules:
- On entry to THIRD, load `remaining` with THIRD_SECONDS. On entry to COOLDOWN, load it with COOLDOWN_SECONDS.
- A `tick` in the entry cycle is not counted.
- In a timed state, each `tick` with `remaining` > 1 decrements `remaining`.
- A `tick` with `remaining` = 1 is expiry: the transition happens on that edge and `remaining` becomes 0.
- In untimed states `remaining` is held at 0, and `tick` is ignored.

## Timing
- All outputs are registered. A request pulse sampled at edge N is visible on `current_mode`/`remaining` after edge N.
- Latency is 1 cycle from request to mode change.
- `third_denied` is high for exactly the cycle after the refused request.
- Expiry: `current_mode` changes on the edge that samples the `tick` with `remaining` = 1. THIRD therefore lasts exactly THIRD_SECONDS ticks after entry.
- `cooldown_active` rises on the COOLDOWN-entry edge and falls on the expiry edge.
- Asserting `rst` at any time, including mid-THIRD or mid-COOLDOWN, forces all reset values immediately, with no wait for `clk`.
- Toggle inputs are pulses. A level held for k cycles counts as k requests: for example, a held first toggle in STAND alternates FIRST/STAND on every cycle. Upstream controllers must pulse.

## Test plan
All scenarios use THIRD_SECONDS = 5 and COOLDOWN_SECONDS = 3.

1. Reset, then `first_mode_toggle` pulse, then `second_mode_toggle` pulse, then `second_mode_toggle` pulse.
   - Required: `current_mode` goes STAND → FIRST → SECOND → STAND, each change 1 cycle after its pulse.
2. From STAND, pulse `third_mode_toggle`, then apply 5 ticks.
   - Required: `remaining` = 5, 4, 3, 2, 1.
   - On the 5th tick, `current_mode` = `` `SECOND_MODE `` and `remaining` = 0.
   - `hurricane_used` = 1 throughout.
3. Second `third_mode_toggle` after scenario 2, sent together with `first_mode_toggle` in the same cycle.
   - Required: `third_denied` pulses for 1 cycle and mode → FIRST.
4. Reset, enter THIRD, apply 2 ticks, then pulse `stand_request`.
   - Required: COOLDOWN with `current_mode` = `` `SECOND_MODE ``, `cooldown_active` = 1, `remaining` = 3.
   - Toggles during COOLDOWN are ignored.
   - The 3rd tick gives STAND with `cooldown_active` = 0.
5. In THIRD with `remaining` = 1, `tick` and `stand_request` arrive in the same cycle.
   - Required: COOLDOWN, not SECOND.
6. Assert `rst` mid-COOLDOWN, then pulse `third_mode_toggle`.
   - Required: all outputs return to their reset values asynchronously.
   - THIRD is re-entered with no denial, since `hurricane_used` was cleared.

Source files
------------

// File: rtl/hood_mode_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : hood_mode_scheduler
// Purpose : Central mode scheduler for the exhaust hood. It owns
//           current_mode and consumes one-cycle toggle pulses from the
//           first/second/third mode controllers. It enforces these rules:
//             - hurricane (THIRD) may be entered only once per reset;
//             - THIRD falls back to SECOND after a timed run;
//             - leaving THIRD early passes through a timed fan COOLDOWN.
// Ports   : clk, rst (async, active-high)
//           tick               - 1 Hz enable pulse, one clk wide
//           first/second/third_mode_toggle, stand_request - request pulses
//           current_mode       - mode encoding (COOLDOWN reports SECOND)
//           remaining          - seconds left in THIRD/COOLDOWN, else 0
//           cooldown_active    - high while in COOLDOWN
//           hurricane_used     - sticky, set on the first THIRD entry
//           third_denied       - one-cycle pulse after a refused THIRD request
// Revision: 1.0 - initial release
// ============================================================================

`ifndef MODE_WIDTH
`define MODE_WIDTH 2
`endif
`ifndef STAND_MODE
`define STAND_MODE 2'd0
`endif
`ifndef FIRST_MODE
`define FIRST_MODE 2'd1
`endif
`ifndef SECOND_MODE
`define SECOND_MODE 2'd2
`endif
`ifndef THIRD_MODE
`define THIRD_MODE 2'd3
`endif

module hood_mode_scheduler #(
  parameter int THIRD_SECONDS    = 60,
  parameter int COOLDOWN_SECONDS = 60,
  parameter int CNT_WIDTH        = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tick,
  input  logic                   first_mode_toggle,
  input  logic                   second_mode_toggle,
  input  logic                   third_mode_toggle,
  input  logic                   stand_request,
  output logic [`MODE_WIDTH-1:0] current_mode,
  output logic [CNT_WIDTH-1:0]   remaining,
  output logic                   cooldown_active,
  output logic                   hurricane_used,
  output logic                   third_denied
);

  localparam logic [CNT_WIDTH-1:0] C_THIRD_LOAD    = CNT_WIDTH'(THIRD_SECONDS);
  localparam logic [CNT_WIDTH-1:0] C_COOLDOWN_LOAD = CNT_WIDTH'(COOLDOWN_SECONDS);
  localparam logic [CNT_WIDTH-1:0] C_ONE           = CNT_WIDTH'(1);

  typedef enum logic [2:0] {
    ST_STAND    = 3'd0,
    ST_FIRST    = 3'd1,
    ST_SECOND   = 3'd2,
    ST_THIRD    = 3'd3,
    ST_COOLDOWN = 3'd4
  } state_t;

  state_t                   state_q, state_d;
  logic [CNT_WIDTH-1:0]     remaining_q, remaining_d;
  logic                     hurricane_used_q, hurricane_used_d;
  logic                     third_denied_q, third_denied_d;
  logic [`MODE_WIDTH-1:0]   current_mode_q, current_mode_d;
  logic                     cooldown_active_q, cooldown_active_d;

  logic                     third_legal;
  logic                     third_illegal;
  // Expiry is the tick that sees the last second; <= also covers a
  // degenerate zero-length load so the timer can never wrap.
  logic                     timer_expire;

  always_comb begin
    third_legal   = third_mode_toggle & ~hurricane_used_q;
    third_illegal = third_mode_toggle &  hurricane_used_q;
    timer_expire  = tick & (remaining_q <= C_ONE);

    state_d          = state_q;
    remaining_d      = remaining_q;
    hurricane_used_d = hurricane_used_q;
    third_denied_d   = 1'b0;

    case (state_q)
      ST_STAND: begin
        remaining_d = '0;
        // stand_request has nothing to do here, so third is the top request.
        if (third_legal) begin
          state_d          = ST_THIRD;
          remaining_d      = C_THIRD_LOAD;
          hurricane_used_d = 1'b1;
        end else begin
          // A refused third request falls through to lower priorities.
          third_denied_d = third_illegal;
          if (second_mode_toggle) begin
            state_d = ST_SECOND;
          end else if (first_mode_toggle) begin
            state_d = ST_FIRST;
          end
        end
      end

      ST_FIRST: begin
        remaining_d = '0;
        if (stand_request) begin
          state_d = ST_STAND;
        end else if (third_legal) begin
          state_d          = ST_THIRD;
          remaining_d      = C_THIRD_LOAD;
          hurricane_used_d = 1'b1;
        end else begin
          third_denied_d = third_illegal;
          if (second_mode_toggle) begin
            state_d = ST_SECOND;
          end else if (first_mode_toggle) begin
            state_d = ST_STAND;
          end
        end
      end

      ST_SECOND: begin
        remaining_d = '0;
        if (stand_request) begin
          state_d = ST_STAND;
        end else if (third_legal) begin
          state_d          = ST_THIRD;
          remaining_d      = C_THIRD_LOAD;
          hurricane_used_d = 1'b1;
        end else begin
          third_denied_d = third_illegal;
          if (second_mode_toggle) begin
            state_d = ST_STAND;
          end else if (first_mode_toggle) begin
            state_d = ST_FIRST;
          end
        end
      end

      ST_THIRD: begin
        // An explicit exit request beats a simultaneous expiry tick.
        if (stand_request || third_mode_toggle) begin
          state_d     = ST_COOLDOWN;
          remaining_d = C_COOLDOWN_LOAD;
        end else if (timer_expire) begin
          state_d     = ST_SECOND;
          remaining_d = '0;
        end else if (tick) begin
          remaining_d = remaining_q - C_ONE;
        end
      end

      ST_COOLDOWN: begin
        // All requests ignored; no denial pulses while the fan winds down.
        if (timer_expire) begin
          state_d     = ST_STAND;
          remaining_d = '0;
        end else if (tick) begin
          remaining_d = remaining_q - C_ONE;
        end
      end

      default: begin
        state_d     = ST_STAND;
        remaining_d = '0;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    case (state_d)
      ST_FIRST:    current_mode_d = `FIRST_MODE;
      ST_SECOND:   current_mode_d = `SECOND_MODE;
      ST_THIRD:    current_mode_d = `THIRD_MODE;
      ST_COOLDOWN: current_mode_d = `SECOND_MODE; // fan still running
      default:     current_mode_d = `STAND_MODE;
    endcase
    cooldown_active_d = (state_d == ST_COOLDOWN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= ST_STAND;
      remaining_q       <= '0;
      hurricane_used_q  <= 1'b0;
      third_denied_q    <= 1'b0;
      current_mode_q    <= `STAND_MODE;
      cooldown_active_q <= 1'b0;
    end else begin
      state_q           <= state_d;
      remaining_q       <= remaining_d;
      hurricane_used_q  <= hurricane_used_d;
      third_denied_q    <= third_denied_d;
      current_mode_q    <= current_mode_d;
      cooldown_active_q <= cooldown_active_d;
    end
  end

  assign current_mode    = current_mode_q;
  assign remaining       = remaining_q;
  assign cooldown_active = cooldown_active_q;
  assign hurricane_used  = hurricane_used_q;
  assign third_denied    = third_denied_q;

endmodule

`default_nettype wire

// File: tb/tb_hood_mode_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_hood_mode_scheduler
// Purpose : Self-checking bench for hood_mode_scheduler with
//           THIRD_SECONDS = 5, COOLDOWN_SECONDS = 3. A table of per-cycle
//           input/expected-output records is applied one clock at a time,
//           followed by a hand-written asynchronous-reset sequence.
// Revision: 1.0 - initial release
// ============================================================================

module tb_hood_mode_scheduler;

  localparam int C_W = 8;
  localparam logic [1:0] M_ST = 2'd0;
  localparam logic [1:0] M_F1 = 2'd1;
  localparam logic [1:0] M_F2 = 2'd2;
  localparam logic [1:0] M_F3 = 2'd3;

  logic           clk = 1'b0;
  logic           rst;
  logic           tick, t1, t2, t3, stand;
  logic [1:0]     current_mode;
  logic [C_W-1:0] remaining;
  logic           cooldown_active, hurricane_used, third_denied;

  int checks = 0;
  int errors = 0;

  hood_mode_scheduler #(
    .THIRD_SECONDS    (5),
    .COOLDOWN_SECONDS (3),
    .CNT_WIDTH        (C_W)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .tick               (tick),
    .first_mode_toggle  (t1),
    .second_mode_toggle (t2),
    .third_mode_toggle  (t3),
    .stand_request      (stand),
    .current_mode       (current_mode),
    .remaining          (remaining),
    .cooldown_active    (cooldown_active),
    .hurricane_used     (hurricane_used),
    .third_denied       (third_denied)
  );

  always #5 clk = ~clk;

  typedef struct {
    string          name;
    logic           rst, tick, t1, t2, t3, stand;
    logic [1:0]     mode;
    logic [C_W-1:0] rem;
    logic           cool, used, denied;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(string n, logic r, logic tk, logic f, logic s,
                              logic t, logic sr, logic [1:0] m, int rm,
                              logic c, logic u, logic d);
    vec_t v;
    v.name = n; v.rst = r; v.tick = tk; v.t1 = f; v.t2 = s; v.t3 = t;
    v.stand = sr; v.mode = m; v.rem = C_W'(rm); v.cool = c; v.used = u;
    v.denied = d;
    return v;
  endfunction

  task automatic check(string n, logic [1:0] m, int rm, logic c, logic u, logic d);
    checks++;
    if (current_mode !== m || remaining !== C_W'(rm) || cooldown_active !== c ||
        hurricane_used !== u || third_denied !== d) begin
      errors++;
      $display("FAIL %s: got mode=%0d rem=%0d cool=%b used=%b denied=%b, want mode=%0d rem=%0d cool=%b used=%b denied=%b",
               n, current_mode, remaining, cooldown_active, hurricane_used,
               third_denied, m, rm, c, u, d);
    end
  endtask

  task automatic drive(logic r, logic tk, logic f, logic s, logic t, logic sr);
    rst = r; tick = tk; t1 = f; t2 = s; t3 = t; stand = sr;
  endtask

  initial begin
    //          name            rst tk t1 t2 t3 sr  mode rem cool used den
    // Basic toggling and tick ignored when untimed
    vq.push_back(mk("s1_first",   0, 0, 1, 0, 0, 0, M_F1, 0, 0, 0, 0));
    vq.push_back(mk("s1_second",  0, 0, 0, 1, 0, 0, M_F2, 0, 0, 0, 0));
    vq.push_back(mk("s1_off",     0, 0, 0, 1, 0, 0, M_ST, 0, 0, 0, 0));
    vq.push_back(mk("untimed_tk", 0, 1, 0, 0, 0, 0, M_ST, 0, 0, 0, 0));
    // Hurricane run to expiry
    vq.push_back(mk("s2_enter",   0, 0, 0, 0, 1, 0, M_F3, 5, 0, 1, 0));
    vq.push_back(mk("s2_t1",      0, 1, 0, 0, 0, 0, M_F3, 4, 0, 1, 0));
    vq.push_back(mk("s2_idle",    0, 0, 0, 0, 0, 0, M_F3, 4, 0, 1, 0));
    vq.push_back(mk("s2_t2",      0, 1, 0, 0, 0, 0, M_F3, 3, 0, 1, 0));
    vq.push_back(mk("s2_t3",      0, 1, 0, 0, 0, 0, M_F3, 2, 0, 1, 0));
    vq.push_back(mk("s2_t4",      0, 1, 0, 0, 0, 0, M_F3, 1, 0, 1, 0));
    vq.push_back(mk("s2_expire",  0, 1, 0, 0, 0, 0, M_F2, 0, 0, 1, 0));
    // Denied hurricane falls through to first
    vq.push_back(mk("s3_deny",    0, 0, 1, 0, 1, 0, M_F1, 0, 0, 1, 1));
    vq.push_back(mk("s3_pulse1",  0, 0, 0, 0, 0, 0, M_F1, 0, 0, 1, 0));
    vq.push_back(mk("deny_alone", 0, 0, 0, 0, 1, 0, M_F1, 0, 0, 1, 1));
    vq.push_back(mk("deny_clr",   0, 0, 0, 0, 0, 0, M_F1, 0, 0, 1, 0));
    vq.push_back(mk("prio_2gt1",  0, 0, 1, 1, 0, 0, M_F2, 0, 0, 1, 0));
    vq.push_back(mk("prio_sgt2",  0, 0, 0, 1, 0, 1, M_ST, 0, 0, 1, 0));
    vq.push_back(mk("stand_nop",  0, 0, 0, 0, 0, 1, M_ST, 0, 0, 1, 0));
    // Early exit through cooldown; tick in entry cycle not counted
    vq.push_back(mk("s4_rst",     1, 0, 0, 0, 0, 0, M_ST, 0, 0, 0, 0));
    vq.push_back(mk("s4_enter",   0, 1, 0, 0, 1, 0, M_F3, 5, 0, 1, 0));
    vq.push_back(mk("s4_t1",      0, 1, 0, 0, 0, 0, M_F3, 4, 0, 1, 0));
    vq.push_back(mk("s4_t2",      0, 1, 0, 0, 0, 0, M_F3, 3, 0, 1, 0));
    vq.push_back(mk("s4_cool",    0, 0, 0, 0, 0, 1, M_F2, 3, 1, 1, 0));
    vq.push_back(mk("s4_ign_all", 0, 1, 1, 1, 1, 0, M_F2, 2, 1, 1, 0));
    vq.push_back(mk("s4_ign_3",   0, 0, 0, 0, 1, 0, M_F2, 2, 1, 1, 0));
    vq.push_back(mk("s4_tk2",     0, 1, 0, 0, 0, 0, M_F2, 1, 1, 1, 0));
    vq.push_back(mk("s4_expire",  0, 1, 0, 0, 0, 0, M_ST, 0, 0, 1, 0));
    // Explicit request beats expiry; first/second ignored in THIRD
    vq.push_back(mk("s5_rst",     1, 0, 0, 0, 0, 0, M_ST, 0, 0, 0, 0));
    vq.push_back(mk("s5_enter",   0, 0, 0, 0, 1, 0, M_F3, 5, 0, 1, 0));
    vq.push_back(mk("s5_ign12",   0, 1, 1, 1, 0, 0, M_F3, 4, 0, 1, 0));
    vq.push_back(mk("s5_t2",      0, 1, 0, 0, 0, 0, M_F3, 3, 0, 1, 0));
    vq.push_back(mk("s5_t3",      0, 1, 0, 0, 0, 0, M_F3, 2, 0, 1, 0));
    vq.push_back(mk("s5_t4",      0, 1, 0, 0, 0, 0, M_F3, 1, 0, 1, 0));
    vq.push_back(mk("s5_win",     0, 1, 0, 0, 0, 1, M_F2, 3, 1, 1, 0));
    vq.push_back(mk("s5_ctk",     0, 1, 0, 0, 0, 0, M_F2, 2, 1, 1, 0));

    // Power-on reset
    drive(1, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", M_ST, 0, 0, 0, 0);
    rst = 1'b0;

    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].tick, vq[i].t1, vq[i].t2, vq[i].t3, vq[i].stand);
      @(posedge clk);
      #1;
      check(vq[i].name, vq[i].mode, int'(vq[i].rem), vq[i].cool, vq[i].used,
            vq[i].denied);
    end

    // Asynchronous reset mid-COOLDOWN: outputs must clear between edges.
    drive(0, 0, 0, 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    check("s6_async_rst", M_ST, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    check("s6_rst_held", M_ST, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0);
    @(posedge clk);
    #1;
    check("s6_reenter", M_F3, 5, 0, 1, 0);
    // A third toggle in THIRD exits to cooldown without a denial.
    drive(0, 0, 0, 0, 1, 0);
    @(posedge clk);
    #1;
    check("s6_t3_exit", M_F2, 3, 1, 1, 0);
    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
